// File: rtl/digit_fetch_ctrl.sv
// ============================================================================
// digit_fetch_ctrl
// ----------------------------------------------------------------------------
// Glyph-ROM fetch controller for the VGA numeric display. It divides the
// scan into NUM_DIGITS horizontally spaced glyph windows. For each pixel that
// lands in a window it issues a registered ROM read enable, a ROM address and
// the digit-slot index. The controller also delays enable and slot by ROM_LAT
// clocks so that they line up with ROM read data for the pixel mixer.
//
// The glyph address is row_base + (x - Xk). row_base is kept as a running
// register that starts at 0 on the top glyph row and grows by GLYPH_W on every
// later row, so no y*GLYPH_W multiply is needed. Only raster-order scanning is
// supported.
//
// Optional feature: when the macro DIGIT_MASK_EN is defined, the block gains
// the input digit_en, a per-slot enable used for leading-zero blanking.
//
// Ports:
//   CLOCK_25    in   1        pixel clock; all logic on the rising edge
//   iRSTn       in   1        synchronous active-low reset
//   x           in   10       current pixel column
//   y           in   10       current pixel row
//   de          in   1        display enable; x/y are valid
//   digit_en    in   NUM_DIGITS  per-slot enable (only with DIGIT_MASK_EN)
//   rdEN        out  1        ROM read enable (registered)
//   addr        out  ADDR_W   ROM address (registered)
//   region_sel  out  SEL_W    digit slot of the current read (registered)
//   pix_valid   out  1        rdEN delayed ROM_LAT clocks
//   pix_sel     out  SEL_W    region_sel delayed ROM_LAT clocks
// ============================================================================
module digit_fetch_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int X0         = 300,
    parameter int Y0         = 300,
    parameter int PITCH      = 85,
    parameter int GLYPH_W    = 70,
    parameter int GLYPH_H    = 140,
    parameter int ADDR_W     = 17,
    parameter int SEL_W      = 2,
    parameter int ROM_LAT    = 1
) (
    input  logic                  CLOCK_25,
    input  logic                  iRSTn,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic                  de,
`ifdef DIGIT_MASK_EN
    input  logic [NUM_DIGITS-1:0] digit_en,
`endif
    output logic                  rdEN,
    output logic [ADDR_W-1:0]     addr,
    output logic [SEL_W-1:0]      region_sel,
    output logic                  pix_valid,
    output logic [SEL_W-1:0]      pix_sel
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [9:0]        prev_y_q;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    // Delay line aligning {rdEN, region_sel} with ROM read data.
    logic              valid_pipe_q [ROM_LAT];
    logic [SEL_W-1:0]  sel_pipe_q   [ROM_LAT];

    // Zero-extended copies so that all comparisons use 32-bit arithmetic.
    logic [31:0] x_ext, y_ext;
    assign x_ext = 32'(x);
    assign y_ext = 32'(y);

    // ------------------------------------------------------------------
    // Row tracking
    // ------------------------------------------------------------------
    logic new_row, in_band;
    assign new_row = (y != prev_y_q);
    assign in_band = (y_ext >= 32'(Y0)) && (y_ext < 32'(Y0 + GLYPH_H));

    // The updated row_base is consumed on the same edge that stores it.
    // X0 >= 1 guarantees that the first pixel of a row (x = 0) never falls
    // in a window, so a stale row_base is never used.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so that no
        // path can leave it unassigned and infer a latch.
        row_base_d = row_base_q;
        if (new_row) begin
            if (y_ext == 32'(Y0)) begin
                row_base_d = '0;
            end else if (y_ext > 32'(Y0) && in_band) begin
                row_base_d = row_base_q + ADDR_W'(GLYPH_W);
            end
        end
    end

    // ------------------------------------------------------------------
    // Window decode: PITCH >= GLYPH_W, so at most one slot can match.
    // ------------------------------------------------------------------
    logic              hit;
    logic [SEL_W-1:0]  hit_sel;
    logic [ADDR_W-1:0] hit_off;

    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        hit_off = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (x_ext >= 32'(X0 + k * PITCH) &&
                x_ext <  32'(X0 + k * PITCH + GLYPH_W)) begin
                hit     = 1'b1;
                hit_sel = SEL_W'(k);
                hit_off = ADDR_W'(x_ext - 32'(X0 + k * PITCH));
            end
        end
    end

    logic slot_en;
`ifdef DIGIT_MASK_EN
    assign slot_en = digit_en[hit_sel];
`else
    assign slot_en = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Output next-state. A masked or missed pixel keeps the last slot index.
    // ------------------------------------------------------------------
    always_comb begin
        rd_en_d = 1'b0;
        addr_d  = '0;
        sel_d   = sel_q;
        if (de && in_band && hit && slot_en) begin
            rd_en_d = 1'b1;
            addr_d  = row_base_d + hit_off;
            sel_d   = hit_sel;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that were present before the edge.
    always_ff @(posedge CLOCK_25) begin
        if (!iRSTn) begin
            prev_y_q   <= '0;
            row_base_q <= '0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            sel_q      <= '0;
        end else begin
            prev_y_q   <= y;
            row_base_q <= row_base_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
        end
    end

    // NOTE: the delay line is explicitly cleared on reset. Without the
    // clear, pix_valid would carry stale reads from before the reset.
    always_ff @(posedge CLOCK_25) begin
        if (!iRSTn) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                valid_pipe_q[i] <= 1'b0;
                sel_pipe_q[i]   <= '0;
            end
        end else begin
            valid_pipe_q[0] <= rd_en_q;
            sel_pipe_q[0]   <= sel_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                valid_pipe_q[i] <= valid_pipe_q[i-1];
                sel_pipe_q[i]   <= sel_pipe_q[i-1];
            end
        end
    end

    assign rdEN       = rd_en_q;
    assign addr       = addr_q;
    assign region_sel = sel_q;
    assign pix_valid  = valid_pipe_q[ROM_LAT-1];
    assign pix_sel    = sel_pipe_q[ROM_LAT-1];

endmodule

// File: tb/tb_digit_fetch_ctrl.sv
// ============================================================================
// tb_digit_fetch_ctrl
// ----------------------------------------------------------------------------
// Directed bench for digit_fetch_ctrl at default geometry with ROM_LAT = 2.
// Inputs are driven after the sampling point. Outputs are read 1 ns after
// each rising edge.
// ============================================================================
module tb_digit_fetch_ctrl;

    localparam int ADDR_W  = 17;
    localparam int SEL_W   = 2;
    localparam int ROM_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [9:0]        x, y;
    logic              de;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  region_sel;
    logic              pix_valid;
    logic [SEL_W-1:0]  pix_sel;
`ifdef DIGIT_MASK_EN
    logic [3:0]        digit_en;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #20 clk = ~clk;

    digit_fetch_ctrl #(.ROM_LAT(ROM_LAT)) dut (
        .CLOCK_25   (clk),
        .iRSTn      (rst_n),
        .x          (x),
        .y          (y),
        .de         (de),
`ifdef DIGIT_MASK_EN
        .digit_en   (digit_en),
`endif
        .rdEN       (rd_en),
        .addr       (addr),
        .region_sel (region_sel),
        .pix_valid  (pix_valid),
        .pix_sel    (pix_sel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walk y in raster order from 0 up to target, using x = 0, one clock per row.
    task automatic goto_row(input int target);
        for (int yy = 0; yy <= target; yy++) begin
            y = 10'(yy);
            x = 10'd0;
            step();
        end
    endtask

    // Reference window decode: returns the slot index, or -1 outside all windows.
    function automatic int slot_of(input int xx);
        for (int k = 0; k < 4; k++)
            if (xx >= 300 + 85 * k && xx < 370 + 85 * k) return k;
        return -1;
    endfunction

    initial begin
        int rd_cnt, addr_errs, en_errs, pv_errs, ps_errs, max_addr, seen;
        logic h1, h2;
        logic [SEL_W-1:0] s1, s2;

        rst_n = 1'b0;
        x = '0;
        y = '0;
        de = 1'b1;
`ifdef DIGIT_MASK_EN
        digit_en = 4'b1111;
`endif
        step();
        step();
        check("rst_rden", 32'(rd_en), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_pvalid", 32'(pix_valid), 0);
        rst_n = 1'b1;

        // First glyph pixel. Its delayed copy appears ROM_LAT clocks later.
        goto_row(300);
        x = 10'd300;
        step();
        check("t1_rden", 32'(rd_en), 1);
        check("t1_addr", 32'(addr), 0);
        check("t1_sel", 32'(region_sel), 0);
        step();
        check("t1_pvalid_early", 32'(pix_valid), 0);
        step();
        check("t1_pvalid", 32'(pix_valid), 1);
        check("t1_psel", 32'(pix_sel), 0);

        // Second row, slot 1, then the gap pixel just right of slot 1.
        goto_row(301);
        x = 10'd454;
        step();
        check("t2_rden", 32'(rd_en), 1);
        check("t2_addr", 32'(addr), 139);
        check("t2_sel", 32'(region_sel), 1);
        x = 10'd455;
        step();
        check("t2_gap_rden", 32'(rd_en), 0);
        check("t2_gap_addr", 32'(addr), 0);
        check("t2_gap_sel_hold", 32'(region_sel), 1);

        // display enable low inside a window
        de = 1'b0;
        x = 10'd420;
        step();
        check("de_low_rden", 32'(rd_en), 0);
        de = 1'b1;

        // Last glyph pixel, then the first row below the band.
        goto_row(439);
        x = 10'd624;
        step();
        check("t3_rden", 32'(rd_en), 1);
        check("t3_addr", 32'(addr), 9799);
        check("t3_sel", 32'(region_sel), 3);
        y = 10'd440;
        step();
        check("t3_below_rden", 32'(rd_en), 0);
        check("t3_below_sel_hold", 32'(region_sel), 3);

        // Mid-frame reset at y=350, x=400 (slot 1, offset 15).
        goto_row(350);
        x = 10'd400;
        step();
        check("rs_pre_addr", 32'(addr), 50 * 70 + 15);
        rst_n = 1'b0;
        step();
        check("rs_rden", 32'(rd_en), 0);
        check("rs_addr", 32'(addr), 0);
        check("rs_sel", 32'(region_sel), 0);
        check("rs_pvalid", 32'(pix_valid), 0);
        check("rs_psel", 32'(pix_sel), 0);
        rst_n = 1'b1;
        y = 10'd351;
        step();
        check("rs_resume_rden", 32'(rd_en), 1);
        check("rs_resume_sel", 32'(region_sel), 1);
        // The next frame's y==300 row brings addresses back in line.
        goto_row(300);
        x = 10'd400;
        step();
        check("rs_recover_r300", 32'(addr), 15);
        goto_row(301);
        x = 10'd400;
        step();
        check("rs_recover_r301", 32'(addr), 85);

`ifdef DIGIT_MASK_EN
        digit_en = 4'b1110;
        goto_row(300);
        x = 10'd310;
        step();
        check("mask_slot0_rden", 32'(rd_en), 0);
        x = 10'd390;
        step();
        check("mask_slot1_rden", 32'(rd_en), 1);
        check("mask_slot1_addr", 32'(addr), 5);
        check("mask_slot1_sel", 32'(region_sel), 1);
        digit_en = 4'b1111;
`endif

        // Frame sweep: blank rows quickly, then every band row over the window span.
        rd_cnt = 0;
        addr_errs = 0;
        en_errs = 0;
        pv_errs = 0;
        ps_errs = 0;
        max_addr = 0;
        seen = 0;
        h1 = 1'b0;
        h2 = 1'b0;
        s1 = '0;
        s2 = '0;
        goto_row(299);
        for (int yy = 300; yy <= 440; yy++) begin
            for (int xx = 290; xx <= 630; xx++) begin
                int k;
                y = 10'(yy);
                x = 10'(xx);
                step();
                k = (yy < 440) ? slot_of(xx) : -1;
                if (rd_en !== (k >= 0)) en_errs++;
                if (rd_en === 1'b1) begin
                    rd_cnt++;
                    if (int'(addr) > max_addr) max_addr = int'(addr);
                    if (k >= 0 && int'(addr) != (yy - 300) * 70 + (xx - 300 - 85 * k))
                        addr_errs++;
                end
                if (seen >= 2) begin
                    if (pix_valid !== h2) pv_errs++;
                    if (pix_sel !== s2) ps_errs++;
                end
                seen++;
                h2 = h1;
                h1 = rd_en;
                s2 = s1;
                s1 = region_sel;
            end
        end
        check("sweep_rden_count", 32'(rd_cnt), 39200);
        check("sweep_rden_pattern_errs", 32'(en_errs), 0);
        check("sweep_addr_errs", 32'(addr_errs), 0);
        check("sweep_max_addr", 32'(max_addr), 9799);
        check("sweep_pvalid_delay_errs", 32'(pv_errs), 0);
        check("sweep_psel_delay_errs", 32'(ps_errs), 0);

        // With the inputs held still, the outputs repeat.
        goto_row(305);
        x = 10'd560;
        step();
        check("stat_addr_a", 32'(addr), 5 * 70 + 5);
        step();
        step();
        check("stat_addr_b", 32'(addr), 5 * 70 + 5);
        check("stat_sel", 32'(region_sel), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
